// File: rtl/conv_window_gen_5x5.sv
// Streaming 5x5 window generator: four line buffers feed a 5x5 shift-register window so every
// full neighbourhood of a raster-order feature map is presented exactly once, stride 1.
module conv_window_gen_5x5 #(
  parameter int unsigned bitwidth   = 16,
  parameter int unsigned map_width  = 28,
  parameter int unsigned map_height = 28,
  localparam int unsigned OutRowW   = (map_height > 5) ? $clog2(map_height - 4) : 1,
  localparam int unsigned OutColW   = (map_width > 5) ? $clog2(map_width - 4) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [bitwidth-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [bitwidth-1:0] map_block [4:0][4:0],
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OutRowW-1:0]         out_row,
  output logic [OutColW-1:0]         out_col,
  output logic                       out_last
);

  localparam int unsigned RowW = $clog2(map_height);
  localparam int unsigned ColW = $clog2(map_width);
  localparam logic [RowW-1:0] RowLast = RowW'(map_height - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(map_width - 1);

  logic [RowW-1:0]            row_q;
  logic [ColW-1:0]            col_q;
  logic                       valid_q;
  logic                       last_q;
  logic [OutRowW-1:0]         orow_q;
  logic [OutColW-1:0]         ocol_q;
  logic signed [bitwidth-1:0] win_q  [4:0][4:0];
  // lb_q[0] holds row r-4, lb_q[3] holds row r-1, all indexed by column.
  logic signed [bitwidth-1:0] lb_q   [4][map_width];
  logic signed [bitwidth-1:0] newcol [4:0];

  logic accept;
  logic row_end;
  logic col_end;
  logic win_hit;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign row_end  = (row_q == RowLast);
  assign col_end  = (col_q == ColLast);
  assign win_hit  = (row_q >= RowW'(4)) && (col_q >= ColW'(4));

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      newcol[k] = lb_q[k][col_q];
    end
    newcol[4] = pixel_in;
  end

  // Each accepted pixel pushes the column up by one row; storage needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < 3; k++) begin
        lb_q[k][col_q] <= lb_q[k+1][col_q];
      end
      lb_q[3][col_q] <= pixel_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      orow_q  <= '0;
      ocol_q  <= '0;
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else if (accept) begin
      col_q <= col_end ? '0 : col_q + ColW'(1);
      if (col_end) begin
        row_q <= row_end ? '0 : row_q + RowW'(1);
      end
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 4; j++) begin
          win_q[i][j] <= win_q[i][j+1];
        end
        win_q[i][4] <= newcol[i];
      end
      valid_q <= win_hit;
      last_q  <= win_hit && row_end && col_end;
      if (win_hit) begin
        orow_q <= OutRowW'(row_q - RowW'(4));
        ocol_q <= OutColW'(col_q - ColW'(4));
      end
    end else if (out_ready) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign map_block = win_q;
  assign out_valid = valid_q;
  assign out_row   = orow_q;
  assign out_col   = ocol_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_conv_window_gen_5x5.sv
// Directed bench for conv_window_gen_5x5: raster frames with a pixel model and a queue of
// expected window positions, plus hand-computed checks of reset, first/last and held windows.
module tb_conv_window_gen_5x5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] pixel_in;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] map_block [4:0][4:0];
  logic               out_valid;
  logic               out_ready;
  logic [4:0]         out_row;
  logic [4:0]         out_col;
  logic               out_last;

  int vectors = 0;
  int errors  = 0;

  // Bench-side raster position of the next pixel to offer, plus expected-window queue.
  int in_r = 0;
  int in_c = 0;
  int qr[$];
  int qc[$];
  int nwin = 0;
  int lastcnt = 0;
  int hotcnt = 0;
  int last_row = -1;
  int last_col = -1;
  logic signed [15:0] last_br = '0;

  conv_window_gen_5x5 #(
    .bitwidth  (16),
    .map_width (28),
    .map_height(28)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pixel_in (pixel_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .map_block(map_block),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row  (out_row),
    .out_col  (out_col),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  function automatic logic signed [15:0] pix(input int kind, input int r, input int c);
    if (kind == 0) return 16'(r * 28 + c);
    return (r == 10 && c == 10) ? 16'h7fff : 16'h8000;
  endfunction

  function automatic int nonzero_cells();
    int n = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        if (map_block[i][j] !== 16'sd0) n++;
    return n;
  endfunction

  task automatic clear_model();
    in_r = 0; in_c = 0;
    qr.delete(); qc.delete();
    nwin = 0; lastcnt = 0; hotcnt = 0;
    last_row = -1; last_col = -1; last_br = '0;
  endtask

  task automatic advance_pos();
    if (in_r >= 4 && in_c >= 4) begin
      qr.push_back(in_r);
      qc.push_back(in_c);
    end
    if (in_c == 27) begin
      in_c = 0;
      in_r = (in_r == 27) ? 0 : in_r + 1;
    end else begin
      in_c = in_c + 1;
    end
  endtask

  task automatic reset_dut();
    in_valid = 1'b0; out_ready = 1'b1; pixel_in = '0;
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_model();
  endtask

  // Streams npix pixels in raster order, then drains; every consumed window is scored.
  task automatic run_pixels(input int kind, input int npix, input int gap, input int bp);
    int acc = 0;
    int cyc = 0;
    int bad;
    int er, ec;
    logic do_acc, do_out;
    while ((acc < npix || out_valid === 1'b1) && cyc < 20000) begin
      in_valid  = (acc < npix) && ($urandom_range(99) >= gap);
      pixel_in  = pix(kind, in_r, in_c);
      out_ready = ($urandom_range(99) >= bp);
      @(negedge clk);
      do_acc = in_valid && in_ready;
      do_out = out_valid && out_ready;
      if (do_out) begin
        vectors++;
        if (qr.size() == 0) begin
          errors++;
          $display("FAIL spurious_window: got row=%0d col=%0d, required no window", out_row,
                   out_col);
        end else begin
          er = qr.pop_front();
          ec = qc.pop_front();
          bad = 0;
          if (out_row !== 5'(er - 4) || out_col !== 5'(ec - 4)) bad++;
          if (out_last !== (er == 27 && ec == 27)) bad++;
          for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
              if (map_block[i][j] !== pix(kind, er - 4 + i, ec - 4 + j)) bad++;
          if (bad != 0) begin
            errors++;
            $display("FAIL window: got row=%0d col=%0d last=%0b br=%0d, required row=%0d col=%0d br=%0d (%0d bad fields)",
                     out_row, out_col, out_last, map_block[4][4], er - 4, ec - 4,
                     pix(kind, er, ec), bad);
          end
          nwin++;
          if (out_last) begin
            lastcnt++;
            last_row = int'(out_row);
            last_col = int'(out_col);
            last_br  = map_block[4][4];
          end
          for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
              if (map_block[i][j] === 16'sh7fff) begin
                hotcnt++;
              end
        end
      end
      if (do_acc) begin
        advance_pos();
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (cyc >= 20000) begin
      errors++;
      $display("FAIL stream_timeout: accepted %0d pixels, required %0d", acc, npix);
    end
  endtask

  // Accepts one pixel while refusing the output, leaving any produced window pending.
  task automatic accept_one(input int kind);
    in_valid  = 1'b1;
    pixel_in  = pix(kind, in_r, in_c);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    advance_pos();
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b1; pixel_in = '0;
    rst_n = 1'b0;
    #12;
    vectors++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_row !== 5'd0 || out_col !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b last=%0b row=%0d col=%0d, required all 0",
               out_valid, out_last, out_row, out_col);
    end
    vectors++;
    if (nonzero_cells() != 0) begin
      errors++;
      $display("FAIL reset_block: got %0d nonzero cells, required 0", nonzero_cells());
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
    end
    clear_model();
  endtask

  task automatic test_full_frame();
    reset_dut();
    run_pixels(0, 116, 0, 0);
    accept_one(0);
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_row !== 5'd0 || out_col !== 5'd0 ||
        out_last !== 1'b0) begin
      errors++;
      $display("FAIL first_window_flags: got valid=%0b ready=%0b row=%0d col=%0d last=%0b, required 1 0 0 0 0",
               out_valid, in_ready, out_row, out_col, out_last);
    end
    vectors++;
    if (map_block[0][0] !== 16'sd0 || map_block[0][4] !== 16'sd4 ||
        map_block[4][0] !== 16'sd112 || map_block[4][4] !== 16'sd116) begin
      errors++;
      $display("FAIL first_window_corners: got %0d %0d %0d %0d, required 0 4 112 116",
               map_block[0][0], map_block[0][4], map_block[4][0], map_block[4][4]);
    end
    run_pixels(0, 784 - 117, 0, 0);
    vectors++;
    if (nwin != 576 || lastcnt != 1 || qr.size() != 0) begin
      errors++;
      $display("FAIL frame_count: got windows=%0d lasts=%0d pending=%0d, required 576 1 0",
               nwin, lastcnt, qr.size());
    end
    vectors++;
    if (last_row != 23 || last_col != 23 || last_br !== 16'sd783) begin
      errors++;
      $display("FAIL last_window: got row=%0d col=%0d br=%0d, required 23 23 783",
               last_row, last_col, last_br);
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    run_pixels(0, 207, 0, 0);
    accept_one(0);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      pixel_in = pix(0, in_r, in_c);
      out_ready = 1'b0;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_row !== 5'd3 || out_col !== 5'd7 ||
          map_block[4][4] !== 16'sd207 || map_block[0][0] !== 16'sd91) begin
        errors++;
        $display("FAIL hold_cycle%0d: got ready=%0b valid=%0b row=%0d col=%0d br=%0d tl=%0d, required 0 1 3 7 207 91",
                 k, in_ready, out_valid, out_row, out_col, map_block[4][4], map_block[0][0]);
      end
      @(posedge clk); #1;
    end
    run_pixels(0, 784 - 208, 0, 0);
    vectors++;
    if (nwin != 576 || lastcnt != 1 || qr.size() != 0) begin
      errors++;
      $display("FAIL backpressure_count: got windows=%0d lasts=%0d pending=%0d, required 576 1 0",
               nwin, lastcnt, qr.size());
    end
  endtask

  task automatic test_random_gaps();
    reset_dut();
    run_pixels(0, 784, 30, 40);
    vectors++;
    if (nwin != 576 || lastcnt != 1 || qr.size() != 0) begin
      errors++;
      $display("FAIL random_count: got windows=%0d lasts=%0d pending=%0d, required 576 1 0",
               nwin, lastcnt, qr.size());
    end
  endtask

  task automatic test_signed();
    reset_dut();
    run_pixels(1, 784, 10, 10);
    vectors++;
    if (nwin != 576 || lastcnt != 1 || hotcnt != 25) begin
      errors++;
      $display("FAIL signed_count: got windows=%0d lasts=%0d hot=%0d, required 576 1 25",
               nwin, lastcnt, hotcnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    reset_dut();
    run_pixels(0, 299, 0, 0);
    accept_one(0);
    vectors++;
    if (out_valid !== 1'b1 || out_row !== 5'd6 || out_col !== 5'd15) begin
      errors++;
      $display("FAIL pre_reset_window: got valid=%0b row=%0d col=%0d, required 1 6 15",
               out_valid, out_row, out_col);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_row !== 5'd0 || out_col !== 5'd0 ||
        nonzero_cells() != 0) begin
      errors++;
      $display("FAIL async_reset: got valid=%0b last=%0b row=%0d col=%0d nonzero=%0d, required all 0",
               out_valid, out_last, out_row, out_col, nonzero_cells());
    end
    #10;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got ready=%0b valid=%0b, required 1 0", in_ready, out_valid);
    end
    clear_model();
  endtask

  task automatic test_back_to_back();
    run_pixels(0, 2 * 784, 0, 0);
    vectors++;
    if (nwin != 1152 || lastcnt != 2 || qr.size() != 0) begin
      errors++;
      $display("FAIL back_to_back: got windows=%0d lasts=%0d pending=%0d, required 1152 2 0",
               nwin, lastcnt, qr.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_random_gaps();
    test_signed();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
